// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: load/store over a req/ack bus with registered writeback.
// Optional bus-ack watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [4:0]  in_wreg_addr,
    input  logic        in_wreg_enable,
    input  logic [31:0] in_wdata,
    input  logic [3:0]  in_memop,
    input  logic [31:0] in_mem_addr,
    input  logic [31:0] in_store_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        stall_req,
    output logic [4:0]  wb_wreg_addr,
    output logic        wb_wreg_enable,
    output logic [31:0] wb_wdata,
    output logic        addr_err,
    output logic [31:0] bad_vaddr,
    output logic        bus_err
);

    typedef enum logic {IDLE, BUS} state_t;

    state_t state, state_nx;

    logic        is_load, is_store, is_byte, is_half, is_word, is_signed;
    logic        mem_op, misaligned, issue;
    logic [3:0]  sel_nx;
    logic [31:0] wdata_nx;

    logic        pend_load, pend_byte, pend_half, pend_signed;
    logic [1:0]  pend_lo;
    logic [31:0] rshift;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_val;
    logic        timeout;

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_word   = 1'b0;
        is_signed = 1'b0;
        case (in_memop)
            4'd1: begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
            4'd2: begin is_load  = 1'b1; is_byte = 1'b1; end
            4'd3: begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
            4'd4: begin is_load  = 1'b1; is_half = 1'b1; end
            4'd5: begin is_load  = 1'b1; is_word = 1'b1; end
            4'd6: begin is_store = 1'b1; is_byte = 1'b1; end
            4'd7: begin is_store = 1'b1; is_half = 1'b1; end
            4'd8: begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
    end

    assign mem_op     = in_valid && (is_load || is_store);
    assign misaligned = (is_half && in_mem_addr[0]) || (is_word && (in_mem_addr[1:0] != 2'b00));
    assign issue      = mem_op && !misaligned;

    // Little-endian lanes; stores replicate so the sel mask alone picks the bytes.
    always_comb begin
        sel_nx   = 4'b1111;
        wdata_nx = in_store_data;
        if (is_byte) begin
            sel_nx   = 4'b0001 << in_mem_addr[1:0];
            wdata_nx = {4{in_store_data[7:0]}};
        end else if (is_half) begin
            sel_nx   = in_mem_addr[1] ? 4'b1100 : 4'b0011;
            wdata_nx = {2{in_store_data[15:0]}};
        end
    end

    always_comb begin
        rshift = bus_rdata >> {pend_lo, 3'b000};
        rbyte  = rshift[7:0];
        rhalf  = pend_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        if (pend_byte)
            load_val = pend_signed ? {{24{rbyte[7]}}, rbyte} : {24'h0, rbyte};
        else if (pend_half)
            load_val = pend_signed ? {{16{rhalf[15]}}, rhalf} : {16'h0, rhalf};
        else
            load_val = bus_rdata;
    end

`ifdef MEM_TIMEOUT_EN
    logic [31:0] to_cnt;

    assign timeout = (state == BUS) && !bus_ack && (to_cnt == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst || state != BUS)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            bus_err <= 1'b0;
        else
            bus_err <= timeout;
    end
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // stall_req drops in the ack (or timeout) cycle so EX/MEM advances on that edge.
    always_comb begin
        state_nx  = state;
        stall_req = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    stall_req = 1'b1;
                    state_nx  = BUS;
                end
            end
            BUS: begin
                if (bus_ack || timeout)
                    state_nx = IDLE;
                else
                    stall_req = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req        <= 1'b0;
            bus_we         <= 1'b0;
            bus_addr       <= '0;
            bus_sel        <= '0;
            bus_wdata      <= '0;
            wb_wreg_addr   <= '0;
            wb_wreg_enable <= 1'b0;
            wb_wdata       <= '0;
            addr_err       <= 1'b0;
            bad_vaddr      <= '0;
            pend_load      <= 1'b0;
            pend_byte      <= 1'b0;
            pend_half      <= 1'b0;
            pend_signed    <= 1'b0;
            pend_lo        <= 2'b00;
        end else begin
            addr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        bus_req        <= 1'b1;
                        bus_we         <= is_store;
                        bus_addr       <= {in_mem_addr[31:2], 2'b00};
                        bus_sel        <= sel_nx;
                        bus_wdata      <= wdata_nx;
                        wb_wreg_enable <= 1'b0;
                        pend_load      <= is_load;
                        pend_byte      <= is_byte;
                        pend_half      <= is_half;
                        pend_signed    <= is_signed;
                        pend_lo        <= in_mem_addr[1:0];
                    end else if (mem_op) begin
                        addr_err       <= 1'b1;
                        bad_vaddr      <= in_mem_addr;
                        wb_wreg_enable <= 1'b0;
                    end else if (in_valid) begin
                        wb_wreg_addr   <= in_wreg_addr;
                        wb_wreg_enable <= in_wreg_enable;
                        wb_wdata       <= in_wdata;
                    end else begin
                        wb_wreg_enable <= 1'b0;
                    end
                end
                BUS: begin
                    wb_wreg_enable <= 1'b0;
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (pend_load) begin
                            wb_wdata       <= load_val;
                            wb_wreg_enable <= in_wreg_enable;
                            wb_wreg_addr   <= in_wreg_addr;
                        end
                    end else if (timeout) begin
                        bus_req <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage (bus responder + writeback monitor).
module tb_mem_stage;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TB_TO = 4;
`else
    localparam int unsigned TB_TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [4:0]  in_wreg_addr = '0;
    logic        in_wreg_enable = 1'b0;
    logic [31:0] in_wdata = '0;
    logic [3:0]  in_memop = '0;
    logic [31:0] in_mem_addr = '0;
    logic [31:0] in_store_data = '0;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_sel;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic        stall_req;
    logic [4:0]  wb_wreg_addr;
    logic        wb_wreg_enable;
    logic [31:0] wb_wdata;
    logic        addr_err;
    logic [31:0] bad_vaddr;
    logic        bus_err;

    mem_stage #(.TIMEOUT_CYCLES(TB_TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_wreg_addr(in_wreg_addr), .in_wreg_enable(in_wreg_enable),
        .in_wdata(in_wdata), .in_memop(in_memop), .in_mem_addr(in_mem_addr),
        .in_store_data(in_store_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .stall_req(stall_req),
        .wb_wreg_addr(wb_wreg_addr), .wb_wreg_enable(wb_wreg_enable), .wb_wdata(wb_wdata),
        .addr_err(addr_err), .bad_vaddr(bad_vaddr), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        bit          no_ack;
    } bus_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    bus_t bus_q[$];
    wb_t  wb_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   bus_episodes = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Writeback monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (wb_wreg_enable === 1'b1) begin
            if (wb_q.size() == 0) begin
                check("wb_unexpected_en", {31'h0, wb_wreg_enable}, 32'h0);
            end else begin
                wb_t e;
                e = wb_q.pop_front();
                check("wb_addr", {27'h0, wb_wreg_addr}, {27'h0, e.addr});
                check("wb_data", wb_wdata, e.data);
            end
        end
    end

    // Bus responder: checks each request against the scoreboard, then acks.
    initial begin
        forever begin
            @(negedge clk);
            if (bus_req === 1'b1) begin
                bus_episodes++;
                if (bus_q.size() == 0) begin
                    check("bus_unexpected_req", {31'h0, bus_req}, 32'h0);
                    for (int k = 0; k < 50 && bus_req === 1'b1; k++) @(negedge clk);
                end else begin
                    bus_t t;
                    t = bus_q.pop_front();
                    check("bus_we", {31'h0, bus_we}, {31'h0, t.we});
                    check("bus_addr", bus_addr, t.addr);
                    check("bus_sel", {28'h0, bus_sel}, {28'h0, t.sel});
                    if (t.we) check("bus_wdata", bus_wdata, t.wdata);
                    if (!t.no_ack) begin
                        repeat (t.delay) @(posedge clk);
                        #1 bus_rdata = t.rdata; bus_ack = 1'b1;
                        @(posedge clk);
                        #1 bus_ack = 1'b0;
                    end else begin
                        for (int k = 0; k < 50 && bus_req === 1'b1; k++) @(negedge clk);
                        check("req_dropped", {31'h0, bus_req}, 32'h0);
                        repeat (3) @(posedge clk);
                        #1 bus_rdata = 32'hFFFF_FFFF; bus_ack = 1'b1;
                        @(posedge clk);
                        #1 bus_ack = 1'b0;
                    end
                end
            end
        end
    end

    // Present one EX/MEM instruction and hold it while stall_req is high.
    task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic we,
                         input logic [31:0] wdata, input logic [31:0] maddr,
                         input logic [31:0] sdata, input int exp_stalls);
        int stalls;
        in_memop = op; in_wreg_addr = rd; in_wreg_enable = we; in_wdata = wdata;
        in_mem_addr = maddr; in_store_data = sdata; in_valid = 1'b1;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (stall_req !== 1'b1) break;
            stalls++;
            if (stalls > 100) break;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("stall_cycles", stalls, exp_stalls);
    endtask

    task automatic alu(input logic [4:0] rd, input logic we, input logic [31:0] d, input logic [3:0] op);
        wb_t e;
        if (we) begin
            e.addr = rd; e.data = d;
            wb_q.push_back(e);
        end
        issue(op, rd, we, d, 32'h0, 32'h0, 0);
    endtask

    task automatic mem(input logic [3:0] op, input logic [4:0] rd, input logic [31:0] maddr,
                       input logic [31:0] sdata, input logic [31:0] rdata,
                       input logic [3:0] sel, input logic [31:0] wdata_exp,
                       input logic [31:0] wb_exp, input int delay);
        bus_t b;
        wb_t  e;
        b.we = (op >= 4'd6); b.addr = {maddr[31:2], 2'b00}; b.sel = sel;
        b.wdata = wdata_exp; b.rdata = rdata; b.delay = delay; b.no_ack = 1'b0;
        bus_q.push_back(b);
        if (!b.we) begin
            e.addr = rd; e.data = wb_exp;
            wb_q.push_back(e);
        end
        issue(op, rd, 1'b1, 32'h5555_0000, maddr, sdata, 1 + delay);
    endtask

    initial begin
        int   ep0;
        logic [31:0] r;
        bus_t b;

        // Reset with a live ALU op held on the inputs.
        in_valid = 1'b1; in_memop = 4'd0; in_wreg_addr = 5'd3; in_wreg_enable = 1'b1;
        in_wdata = 32'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bus_req", {31'h0, bus_req}, 32'h0);
        check("rst_wb_en", {31'h0, wb_wreg_enable}, 32'h0);
        check("rst_wb_data", wb_wdata, 32'h0);
        check("rst_addr_err", {31'h0, addr_err}, 32'h0);
        check("rst_bad_vaddr", bad_vaddr, 32'h0);
        check("rst_bus_err", {31'h0, bus_err}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        alu(5'd3, 1'b1, 32'h1234, 4'd0);

        // ALU ops, including a no-write op and memop codes 9-15 treated as NONE.
        for (int i = 0; i < 4; i++) alu(5'(i + 8), 1'b1, $urandom, 4'd0);
        alu(5'd9, 1'b0, 32'hCAFE_F00D, 4'd0);
        alu(5'd10, 1'b1, 32'h0BAD_0009, 4'd9);
        alu(5'd11, 1'b1, 32'h0BAD_000F, 4'd15);
        repeat (2) @(posedge clk);
        #1;

        // Loads and stores across all widths and lanes.
        mem(4'd1, 5'd4, 32'h103, 32'h0, 32'h80FF_0000, 4'b1000, 32'h0, 32'hFFFF_FF80, 2);
        mem(4'd2, 5'd5, 32'h103, 32'h0, 32'h80FF_0000, 4'b1000, 32'h0, 32'h0000_0080, 2);
        mem(4'd7, 5'd6, 32'h202, 32'hAAAA_BEEF, 32'h0, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1);
        mem(4'd3, 5'd7, 32'h102, 32'h0, 32'h8001_1234, 4'b1100, 32'h0, 32'hFFFF_8001, 1);
        mem(4'd4, 5'd8, 32'h100, 32'h0, 32'h8001_9234, 4'b0011, 32'h0, 32'h0000_9234, 3);
        mem(4'd1, 5'd9, 32'h101, 32'h0, 32'h1122_7F44, 4'b0010, 32'h0, 32'h0000_007F, 1);
        mem(4'd6, 5'd12, 32'h005, 32'h1234_56A5, 32'h0, 4'b0010, 32'hA5A5_A5A5, 32'h0, 1);
        mem(4'd8, 5'd13, 32'h040, 32'hDEAD_BEEF, 32'h0, 4'b1111, 32'hDEAD_BEEF, 32'h0, 2);
        r = $urandom;
        mem(4'd5, 5'd14, 32'h020, 32'h0, r, 4'b1111, 32'h0, r, 1);

        // Misaligned word load: error pulse, no bus access.
        issue(4'd5, 5'd15, 1'b1, 32'h0, 32'h301, 32'h0, 0);
        @(negedge clk);
        check("mis_addr_err", {31'h0, addr_err}, 32'h1);
        check("mis_bad_vaddr", bad_vaddr, 32'h301);
        check("mis_wb_en", {31'h0, wb_wreg_enable}, 32'h0);
        check("mis_bus_req", {31'h0, bus_req}, 32'h0);
        @(negedge clk);
        check("mis_pulse_end", {31'h0, addr_err}, 32'h0);
        check("mis_bad_vaddr_held", bad_vaddr, 32'h301);
        @(posedge clk);
        #1 issue(4'd7, 5'd16, 1'b1, 32'h0, 32'h403, 32'h0, 0);
        @(negedge clk);
        check("mis_sh_err", {31'h0, addr_err}, 32'h1);
        check("mis_sh_vaddr", bad_vaddr, 32'h403);
        @(posedge clk);
        #1;

        // Back-to-back LW then SW.
        ep0 = bus_episodes;
        mem(4'd5, 5'd17, 32'h010, 32'h0, 32'h0A0B_0C0D, 4'b1111, 32'h0, 32'h0A0B_0C0D, 1);
        mem(4'd8, 5'd18, 32'h014, 32'h7777_1111, 32'h0, 4'b1111, 32'h7777_1111, 32'h0, 1);
        repeat (3) @(posedge clk);
        check("b2b_episodes", bus_episodes - ep0, 32'd2);
        #1;

        // Reset while waiting for ack; a later ack must not write back.
        b.we = 1'b0; b.addr = 32'h60; b.sel = 4'b1111; b.wdata = 32'h0; b.rdata = 32'h0;
        b.delay = 0; b.no_ack = 1'b1;
        bus_q.push_back(b);
        in_memop = 4'd5; in_wreg_addr = 5'd19; in_wreg_enable = 1'b1; in_mem_addr = 32'h60;
        in_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstbus_req", {31'h0, bus_req}, 32'h0);
        check("rstbus_wb_en", {31'h0, wb_wreg_enable}, 32'h0);
        check("rstbus_stall", {31'h0, stall_req}, 32'h0);
        repeat (8) @(posedge clk);
        #1;

`ifdef MEM_TIMEOUT_EN
        b.addr = 32'h80; bus_q.push_back(b);
        issue(4'd5, 5'd20, 1'b1, 32'h0, 32'h80, 32'h0, 4);
        @(negedge clk);
        check("to_bus_err", {31'h0, bus_err}, 32'h1);
        check("to_bus_req", {31'h0, bus_req}, 32'h0);
        check("to_wb_en", {31'h0, wb_wreg_enable}, 32'h0);
        @(negedge clk);
        check("to_pulse_end", {31'h0, bus_err}, 32'h0);
        repeat (8) @(posedge clk);
        #1;
`endif

        alu(5'd21, 1'b1, 32'h600D_0001, 4'd0);
        repeat (4) @(posedge clk);
        check("wb_q_empty", wb_q.size(), 32'd0);
        check("bus_q_empty", bus_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
        $fatal(1);
    end

endmodule
